// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
// Bundles the execute-stage operand, control and result signals of
// alu_exec_unit. Clock and reset stay outside as plain module ports.
//
// Signals
//   en_i        output-register load enable (0 = stall, hold)
//   ALUOp_i     operation class from main control
//   funct_i     instruction funct field / immediate bits [5:0]
//   data1_i     ALU operand A
//   data2_i     ALU operand B
//   add_a_i     free-standing adder operand A
//   add_b_i     free-standing adder operand B
//   ALUCtrl_o   decoded ALU control code (combinational)
//   data_o      ALU result (combinational)
//   zero_o      data_o == 0 (combinational)
//   add_o       add_a_i + add_b_i (combinational)
//   result_q_o  registered ALU result
//   zero_q_o    registered zero flag
//
// Modports
//   master  drives operands/control, observes results (pipeline / bench)
//   slave   the execute unit itself
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);

  logic             en_i;
  logic [1:0]       ALUOp_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] add_a_i;
  logic [WIDTH-1:0] add_b_i;

  logic [2:0]       ALUCtrl_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic [WIDTH-1:0] add_o;
  logic [WIDTH-1:0] result_q_o;
  logic             zero_q_o;

  modport master (
    output en_i,
    output ALUOp_i,
    output funct_i,
    output data1_i,
    output data2_i,
    output add_a_i,
    output add_b_i,
    input  ALUCtrl_o,
    input  data_o,
    input  zero_o,
    input  add_o,
    input  result_q_o,
    input  zero_q_o
  );

  modport slave (
    input  en_i,
    input  ALUOp_i,
    input  funct_i,
    input  data1_i,
    input  data2_i,
    input  add_a_i,
    input  add_b_i,
    output ALUCtrl_o,
    output data_o,
    output zero_o,
    output add_o,
    output result_q_o,
    output zero_q_o
  );

endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage arithmetic block of the 5-stage MIPS pipeline:
//   - ALU-control decode (ALUOp + funct -> 3-bit control code)
//   - WIDTH-bit ALU (and, or, add, sub, mul low half, signed slt)
//   - free-standing WIDTH-bit adder for PC+4 / branch target
//   - one-cycle output register (result + zero) toward EX/MEM
//
// Ports
//   clk_i    clock, rising-edge active
//   rst_n_i  asynchronous active-low reset; clears only the output register
//   bus      alu_exec_unit_if.slave: operands, control, results
//
// The combinational outputs never see reset; only result_q_o / zero_q_o do.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  alu_exec_unit_if.slave bus
);

  // ALUOp classes from main control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct encodings
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_MUL = 3'b011;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] prod_lo;
  logic             lt_signed;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  assign op_a = bus.data1_i;
  assign op_b = bus.data2_i;

  // -------------------------------------------------------------------------
  // ALU control decode
  // -------------------------------------------------------------------------
  always_comb begin
    alu_ctrl = CTRL_ADD;
    case (bus.ALUOp_i)
      ALUOP_ADD: alu_ctrl = CTRL_ADD;
      ALUOP_SUB: alu_ctrl = CTRL_SUB;
      ALUOP_OR:  alu_ctrl = CTRL_OR;
      ALUOP_RTYPE: begin
        case (bus.funct_i)
          FUNCT_ADD: alu_ctrl = CTRL_ADD;
          FUNCT_SUB: alu_ctrl = CTRL_SUB;
          FUNCT_AND: alu_ctrl = CTRL_AND;
          FUNCT_OR:  alu_ctrl = CTRL_OR;
          FUNCT_MUL: alu_ctrl = CTRL_MUL;
          FUNCT_SLT: alu_ctrl = CTRL_SLT;
          // unknown R-type funct degrades to add rather than trapping
          default:   alu_ctrl = CTRL_ADD;
        endcase
      end
      default: alu_ctrl = CTRL_ADD;
    endcase
  end

  // -------------------------------------------------------------------------
  // ALU datapath
  // -------------------------------------------------------------------------
  // Add/sub/mul all wrap; the low WIDTH bits of a product are the same for
  // signed and unsigned operands, so a plain unsigned multiply suffices.
  assign sum_ab    = op_a + op_b;
  assign diff_ab   = op_a - op_b;
  assign prod_lo   = op_a * op_b;
  assign lt_signed = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      CTRL_AND: alu_res = op_a & op_b;
      CTRL_OR:  alu_res = op_a | op_b;
      CTRL_ADD: alu_res = sum_ab;
      CTRL_SUB: alu_res = diff_ab;
      CTRL_MUL: alu_res = prod_lo;
      CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt_signed};
      // codes 100 and 101 are never decoded; keep them at a defined zero
      default:  alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // -------------------------------------------------------------------------
  // EX/MEM output register; reset wins over enable
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (bus.en_i) begin
      result_q <= alu_res;
      zero_q   <= alu_zero;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ALUCtrl_o  = alu_ctrl;
  assign bus.data_o     = alu_res;
  assign bus.zero_o     = alu_zero;
  // PC-path adder is kept apart from the ALU so branch targets never
  // contend with the main operation; carry-out is dropped.
  assign bus.add_o      = bus.add_a_i + bus.add_b_i;
  assign bus.result_q_o = result_q;
  assign bus.zero_q_o   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W = 32;

  localparam int S_CTRL = 0;
  localparam int S_DATA = 1;
  localparam int S_ZERO = 2;
  localparam int S_ADD  = 3;
  localparam int S_RQ   = 4;
  localparam int S_ZQ   = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic rst_n;

  sb_t sb_q[$];
  int  n_vec;
  int  n_err;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_CTRL:  return {29'd0, bus.ALUCtrl_o};
      S_DATA:  return bus.data_o;
      S_ZERO:  return {31'd0, bus.zero_o};
      S_ADD:   return bus.add_o;
      S_RQ:    return bus.result_q_o;
      S_ZQ:    return {31'd0, bus.zero_q_o};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] e);
    sb_t item;
    item.tag = tag;
    item.sel = sel;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  // pop every pending expectation and compare against the DUT right now
  task automatic drain();
    sb_t         item;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      obs  = observe(item.sel);
      n_vec++;
      assert (obs === item.exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic set_alu(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    bus.ALUOp_i = op;
    bus.funct_i = fn;
    bus.data1_i = a;
    bus.data2_i = b;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.en_i    = 1'b1;
    bus.add_a_i = 32'd0;
    bus.add_b_i = 32'd0;
    set_alu(2'b00, 6'd0, 32'd5, 32'd3);

    // reset held across edges with en high: registers stay cleared
    repeat (3) @(posedge clk);
    #1;
    expect_val("rst_result_q", S_RQ, 32'd0);
    expect_val("rst_zero_q", S_ZQ, 32'd0);
    expect_val("rst_data_comb", S_DATA, 32'd8);
    expect_val("rst_ctrl", S_CTRL, 32'd2);
    expect_val("rst_add_comb", S_ADD, 32'd0);
    drain();

    @(negedge clk);
    rst_n = 1'b1;

    // R-type decode sweep, A=0xC B=0xA
    set_alu(2'b10, 6'b100000, 32'hC, 32'hA);
    expect_val("rt_add_ctrl", S_CTRL, 32'd2);
    expect_val("rt_add_data", S_DATA, 32'h16);
    #1; drain();
    set_alu(2'b10, 6'b100010, 32'hC, 32'hA);
    expect_val("rt_sub_ctrl", S_CTRL, 32'd6);
    expect_val("rt_sub_data", S_DATA, 32'h2);
    #1; drain();
    set_alu(2'b10, 6'b100100, 32'hC, 32'hA);
    expect_val("rt_and_ctrl", S_CTRL, 32'd0);
    expect_val("rt_and_data", S_DATA, 32'h8);
    #1; drain();
    set_alu(2'b10, 6'b100101, 32'hC, 32'hA);
    expect_val("rt_or_ctrl", S_CTRL, 32'd1);
    expect_val("rt_or_data", S_DATA, 32'hE);
    #1; drain();
    set_alu(2'b10, 6'b011000, 32'hC, 32'hA);
    expect_val("rt_mul_ctrl", S_CTRL, 32'd3);
    expect_val("rt_mul_data", S_DATA, 32'h78);
    #1; drain();
    set_alu(2'b10, 6'b101010, 32'hC, 32'hA);
    expect_val("rt_slt_ctrl", S_CTRL, 32'd7);
    expect_val("rt_slt_data", S_DATA, 32'h0);
    expect_val("rt_slt_zero", S_ZERO, 32'd1);
    #1; drain();
    set_alu(2'b10, 6'b000000, 32'hC, 32'hA);
    expect_val("rt_dflt_ctrl", S_CTRL, 32'd2);
    expect_val("rt_dflt_data", S_DATA, 32'h16);
    expect_val("rt_dflt_zero", S_ZERO, 32'd0);
    #1; drain();

    // non-R ALUOp and branch compare
    set_alu(2'b01, 6'b100101, 32'h1234, 32'h1234);
    expect_val("beq_ctrl", S_CTRL, 32'd6);
    expect_val("beq_data", S_DATA, 32'd0);
    expect_val("beq_zero", S_ZERO, 32'd1);
    #1; drain();
    set_alu(2'b11, 6'b100010, 32'hF0, 32'h0F);
    expect_val("ori_ctrl", S_CTRL, 32'd1);
    expect_val("ori_data", S_DATA, 32'hFF);
    #1; drain();

    // boundaries
    set_alu(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1);
    expect_val("add_wrap_data", S_DATA, 32'd0);
    expect_val("add_wrap_zero", S_ZERO, 32'd1);
    #1; drain();
    set_alu(2'b01, 6'b000000, 32'd0, 32'd1);
    expect_val("sub_wrap_data", S_DATA, 32'hFFFF_FFFF);
    expect_val("sub_wrap_zero", S_ZERO, 32'd0);
    #1; drain();
    set_alu(2'b10, 6'b101010, 32'h8000_0000, 32'd1);
    expect_val("slt_neg_data", S_DATA, 32'd1);
    #1; drain();
    set_alu(2'b10, 6'b101010, 32'd1, 32'h8000_0000);
    expect_val("slt_rev_data", S_DATA, 32'd0);
    #1; drain();
    set_alu(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0000);
    expect_val("mul_trunc_data", S_DATA, 32'd0);
    expect_val("mul_trunc_zero", S_ZERO, 32'd1);
    #1; drain();
    set_alu(2'b10, 6'b011000, 32'hFFFF_FFFE, 32'd3);
    expect_val("mul_neg_data", S_DATA, 32'hFFFF_FFFA);
    #1; drain();

    // register timing and stall
    @(negedge clk);
    bus.en_i = 1'b1;
    set_alu(2'b00, 6'd0, 32'd2, 32'd3);
    expect_val("reg_load5", S_RQ, 32'd5);
    expect_val("reg_load5_zq", S_ZQ, 32'd0);
    @(posedge clk); #1; drain();

    @(negedge clk);
    bus.en_i = 1'b0;
    set_alu(2'b00, 6'd0, 32'd7, 32'd1);
    expect_val("reg_stall_hold", S_RQ, 32'd5);
    expect_val("reg_stall_comb", S_DATA, 32'd8);
    @(posedge clk); #1; drain();

    @(negedge clk);
    bus.en_i = 1'b1;
    expect_val("reg_resume8", S_RQ, 32'd8);
    @(posedge clk); #1; drain();

    // async reset mid-run clears a loaded result without a clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("async_rst_rq", S_RQ, 32'd0);
    expect_val("async_rst_comb", S_DATA, 32'd8);
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // load a zero result, then clear the zero flag asynchronously
    set_alu(2'b00, 6'd0, 32'd0, 32'd0);
    expect_val("reg_zero_q", S_ZQ, 32'd1);
    expect_val("reg_zero_rq", S_RQ, 32'd0);
    @(posedge clk); #1; drain();
    #3;
    rst_n = 1'b0;
    #1;
    expect_val("async_rst_zq", S_ZQ, 32'd0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // free-standing adder, ALU path left untouched
    set_alu(2'b10, 6'b100101, 32'hF0, 32'h0F);
    bus.add_a_i = 32'h0040_0000;
    bus.add_b_i = 32'd4;
    expect_val("pc_plus4", S_ADD, 32'h0040_0004);
    expect_val("pc_plus4_alu", S_DATA, 32'hFF);
    #1; drain();
    bus.add_a_i = 32'hFFFF_FFFC;
    bus.add_b_i = 32'd8;
    expect_val("adder_wrap", S_ADD, 32'h0000_0004);
    expect_val("adder_wrap_alu", S_DATA, 32'hFF);
    #1; drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage arithmetic block of the 5-stage MIPS pipeline.
- Integrates three functions:
  - ALU-control decode: ALUOp plus funct produce a 3-bit ALU control code.
  - 32-bit ALU.
  - Free-standing 32-bit adder, used for PC+4 and branch-target computation.
- ALU result and zero flag are available combinationally and through a one-cycle output register feeding the EX/MEM boundary.

Parameters:
- WIDTH, 32, datapath width of ALU operands, adder operands and results.

Ports:
- clk_i  input  1  clock, rising-edge active.
- rst_n_i  input  1  asynchronous active-low reset.
- en_i  input  1  output-register load enable; 0 holds registered outputs (stall).
- ALUOp_i  input  2  operation class from main control.
- funct_i  input  6  instruction funct field, immediate bits [5:0].
- data1_i  input  WIDTH  ALU operand A (forwarded RS).
- data2_i  input  WIDTH  ALU operand B (forwarded RT or sign-extended immediate).
- add_a_i  input  WIDTH  adder operand A.
- add_b_i  input  WIDTH  adder operand B.
- ALUCtrl_o  output  3  decoded ALU control, combinational.
- data_o  output  WIDTH  ALU result, combinational.
- zero_o  output  1  1 when data_o == 0, combinational.
- add_o  output  WIDTH  add_a_i + add_b_i, combinational.
- result_q_o  output  WIDTH  registered ALU result.
- zero_q_o  output  1  registered zero flag.

Behaviour:
- ALU control decode (combinational):
  - ALUOp 00 -> 010 (add: lw/sw/addi).
  - ALUOp 01 -> 110 (sub: beq).
  - ALUOp 11 -> 001 (or: ori).
  - ALUOp 10 -> decode funct:
    - 100000 -> 010 add
    - 100010 -> 110 sub
    - 100100 -> 000 and
    - 100101 -> 001 or
    - 011000 -> 011 mul
    - 101010 -> 111 slt
    - any other funct -> 010 add
- ALU operations (combinational, selected by ALUCtrl_o):
  - 000: A & B.
  - 001: A | B.
  - 010: A + B.
  - 110: A - B.
  - 011: low WIDTH bits of A * B.
  - 111: 1 if signed(A) < signed(B), else 0.
  - Unused codes 100 and 101 -> result 0.
- Arithmetic rules:
  - Add/sub wrap modulo 2^WIDTH.
  - No overflow detection, no exception.
  - Mul product truncated to WIDTH bits; operands treated as signed, but the low bits are identical either way.
- zero_o follows data_o for every operation.
- Adder: add_o = add_a_i + add_b_i modulo 2^WIDTH, carry discarded. Fully independent of the ALU path.
- Output register:
  - rst_n_i low, at any time including mid-operation, forces result_q_o = 0 and zero_q_o = 0 immediately (asynchronous).
  - After reset release, on each rising clk_i with en_i = 1: result_q_o <= data_o, zero_q_o <= zero_o. Latency is 1 cycle.
  - en_i = 0 holds the previous registered values.
  - Reset has priority over en_i.
- Combinational outputs are unaffected by rst_n_i and reflect the inputs at all times.
- The block contains no other state.

Test Plan:
- Reset: hold rst_n_i = 0 with data1_i = 5, data2_i = 3, ALUOp 00 -> result_q_o = 0, zero_q_o = 0 while data_o = 8. Assert reset mid-run after a load -> registered outputs clear without a clock edge.
- R-type decode sweep: ALUOp 10, A = 0x0000000C, B = 0x0000000A.
  - funct 100000 -> ALUCtrl 010, data 0x16.
  - funct 100010 -> 110, data 0x2.
  - funct 100100 -> 000, data 0x8.
  - funct 100101 -> 001, data 0xE.
  - funct 011000 -> 011, data 0x78.
  - funct 101010 -> 111, data 0.
  - funct 000000 -> 010.
- Non-R ALUOp and branch compare:
  - ALUOp 01, A = B = 0x1234 -> data 0, zero_o = 1.
  - ALUOp 11, A = 0xF0, B = 0x0F -> ALUCtrl 001, data 0xFF.
- Boundaries:
  - add 0xFFFFFFFF + 1 -> 0, zero_o = 1.
  - sub 0 - 1 -> 0xFFFFFFFF.
  - slt 0x80000000 vs 1 -> 1.
  - mul 0x00010000 * 0x00010000 -> 0.
- Register timing and stall:
  - Apply add 2 + 3 with en_i = 1 -> result_q_o = 5 one edge later.
  - Change operands to 7 + 1 with en_i = 0 -> result_q_o stays 5.
  - Raise en_i -> 8 on the next edge.
- Adder:
  - add_a_i = 0x00400000, add_b_i = 4 -> add_o = 0x00400004.
  - 0xFFFFFFFC + 8 -> 0x00000004.
  - Neither stimulus changes data_o.
